awmc_cycle_sequencer: RTL and testbench



---
 rtl/awmc_pkg.sv | 50 +++++
 rtl/awmc_stage_timer.sv | 30 +++
 rtl/awmc_cycle_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_awmc_cycle_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/awmc_pkg.sv
// Shared stage/program encodings and the per-program stage duration rule for the
// washing machine sequencer.
package awmc_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StFill  = 3'd1,
        StWash  = 3'd2,
        StRinse = 3'd3,
        StSpin  = 3'd4,
        StDone  = 3'd5
    } stage_e;

    typedef enum logic [1:0] {
        ProgNormal = 2'd0,
        ProgQuick  = 2'd1,
        ProgHeavy  = 2'd2
    } prog_e;

    function automatic logic stage_running(stage_e st);
        return (st == StFill) || (st == StWash) || (st == StRinse) || (st == StSpin);
    endfunction

    // Select code 3 is unassigned on the panel and falls back to the normal program.
    function automatic prog_e decode_prog(logic [1:0] sel);
        return (sel == 2'd3) ? ProgNormal : prog_e'(sel);
    endfunction

    // Result is already saturated to the cnt_w-bit range and never zero.
    function automatic int unsigned stage_duration(prog_e prog, stage_e st, int unsigned cnt_w,
                                                   int unsigned fill_t, int unsigned wash_t,
                                                   int unsigned rinse_t, int unsigned spin_t);
        longint unsigned max_d;
        longint unsigned d;
        max_d = (64'd1 << cnt_w) - 64'd1;
        case (st)
            StFill:  d = 64'(fill_t);
            StWash:  d = 64'(wash_t);
            StRinse: d = 64'(rinse_t);
            StSpin:  d = 64'(spin_t);
            default: d = 64'd0;
        endcase
        if (prog == ProgQuick && (st == StWash || st == StRinse)) d = d >> 1;
        if (prog == ProgHeavy && st == StWash) d = d << 1;
        if (d > max_d) d = max_d;
        if (d == 64'd0) d = 64'd1;
        return 32'(d);
    endfunction

endpackage

// File: rtl/awmc_stage_timer.sv
// Loadable down-counter that times one sequencer stage; last flags the final tick.
module awmc_stage_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    input  logic             tick,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en && tick && count_q != '0) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign count = count_q;
    assign last  = (count_q == CNT_W'(1));

endmodule

// File: rtl/awmc_cycle_sequencer.sv
// Wash cycle sequencer: FILL -> WASH -> RINSE -> SPIN -> DONE with pause/lid interlock.
// Define AWMC_DOUBLE_RINSE_EN to insert a second FILL + RINSE pass before SPIN.
module awmc_cycle_sequencer
    import awmc_pkg::*;
#(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned FILL_T  = 4,
    parameter int unsigned WASH_T  = 8,
    parameter int unsigned RINSE_T = 6,
    parameter int unsigned SPIN_T  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pause,
    input  logic             lid,
    input  logic [1:0]       prog_sel,
    input  logic             tick,
    output logic [2:0]       stage,
    output logic             fill_valve,
    output logic             motor_en,
    output logic             motor_spin,
    output logic             drain_pump,
    output logic             lid_lock,
    output logic             done,
    output logic [CNT_W-1:0] remaining
);

    stage_e stage_q, stage_d;
    prog_e  prog_q, prog_d;
`ifdef AWMC_DOUBLE_RINSE_EN
    logic   pass_q, pass_d;
`endif

    logic             run_en;
    logic             advance;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic [CNT_W-1:0] tmr_count;
    logic             tmr_last;
    logic             fill_d, motor_d, spin_d, drain_d;
    logic             fill_q, motor_q, spin_q, drain_q;

    assign run_en  = !pause && lid;
    assign advance = tick && run_en && tmr_last;

    awmc_stage_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (stage_running(stage_q) && run_en),
        .tick     (tick),
        .count    (tmr_count),
        .last     (tmr_last)
    );

    always_comb begin
        stage_d  = stage_q;
        prog_d   = prog_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
`ifdef AWMC_DOUBLE_RINSE_EN
        pass_d   = pass_q;
`endif
        case (stage_q)
            StIdle, StDone: begin
                if (start && lid) begin
                    stage_d  = StFill;
                    prog_d   = decode_prog(prog_sel);
                    tmr_load = 1'b1;
`ifdef AWMC_DOUBLE_RINSE_EN
                    pass_d   = 1'b0;
`endif
                end else if (stage_q == StDone && !start && !lid) begin
                    stage_d = StIdle;
                end
            end
            StFill: begin
                if (advance) begin
                    tmr_load = 1'b1;
                    stage_d  = StWash;
`ifdef AWMC_DOUBLE_RINSE_EN
                    if (pass_q) stage_d = StRinse;
`endif
                end
            end
            StWash: begin
                if (advance) begin
                    tmr_load = 1'b1;
                    stage_d  = StRinse;
                end
            end
            StRinse: begin
                if (advance) begin
                    tmr_load = 1'b1;
`ifdef AWMC_DOUBLE_RINSE_EN
                    if (!pass_q) begin
                        stage_d = StFill;
                        pass_d  = 1'b1;
                    end else begin
                        stage_d = StSpin;
                    end
`else
                    stage_d  = StSpin;
`endif
                end
            end
            StSpin: begin
                if (advance) begin
                    tmr_load = 1'b1;
                    stage_d  = StDone;
                end
            end
            default: stage_d = StIdle;
        endcase

        // Entering DONE loads zero so the timer is parked.
        if (tmr_load && stage_running(stage_d)) begin
            tmr_val = CNT_W'(stage_duration(prog_d, stage_d, CNT_W, FILL_T, WASH_T, RINSE_T,
                                            SPIN_T));
        end

        fill_d  = 1'b0;
        motor_d = 1'b0;
        spin_d  = 1'b0;
        drain_d = 1'b0;
        if (run_en) begin
            case (stage_d)
                StFill:  fill_d = 1'b1;
                StWash:  motor_d = 1'b1;
                StRinse: begin
                    fill_d  = 1'b1;
                    motor_d = 1'b1;
                end
                StSpin: begin
                    spin_d  = 1'b1;
                    drain_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q <= StIdle;
            prog_q  <= ProgNormal;
            fill_q  <= 1'b0;
            motor_q <= 1'b0;
            spin_q  <= 1'b0;
            drain_q <= 1'b0;
`ifdef AWMC_DOUBLE_RINSE_EN
            pass_q  <= 1'b0;
`endif
        end else begin
            stage_q <= stage_d;
            prog_q  <= prog_d;
            fill_q  <= fill_d;
            motor_q <= motor_d;
            spin_q  <= spin_d;
            drain_q <= drain_d;
`ifdef AWMC_DOUBLE_RINSE_EN
            pass_q  <= pass_d;
`endif
        end
    end

    assign stage      = stage_q;
    assign fill_valve = fill_q;
    assign motor_en   = motor_q;
    assign motor_spin = spin_q;
    assign drain_pump = drain_q;
    assign lid_lock   = stage_running(stage_q);
    assign done       = (stage_q == StDone);
    assign remaining  = stage_running(stage_q) ? tmr_count : '0;

endmodule

// File: tb/tb_awmc_cycle_sequencer.sv
// Scoreboard bench for awmc_cycle_sequencer: a stage-plan model predicts every cycle's outputs.
`timescale 1ns/1ps
module tb_awmc_cycle_sequencer;

    localparam int CNT_W = 8;
`ifdef AWMC_DOUBLE_RINSE_EN
    localparam int NORM_T  = 33;
    localparam int QUICK_T = 23;
    localparam int HEAVY_T = 41;
`else
    localparam int NORM_T  = 23;
    localparam int QUICK_T = 16;
    localparam int HEAVY_T = 31;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1, start = 1'b0, pause = 1'b0, lid = 1'b1, tick = 1'b0;
    logic [1:0] prog_sel = 2'd0;
    logic [2:0] stage;
    logic fill_valve, motor_en, motor_spin, drain_pump, lid_lock, done;
    logic [CNT_W-1:0] remaining;

    awmc_cycle_sequencer #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pause      (pause),
        .lid        (lid),
        .prog_sel   (prog_sel),
        .tick       (tick),
        .stage      (stage),
        .fill_valve (fill_valve),
        .motor_en   (motor_en),
        .motor_spin (motor_spin),
        .drain_pump (drain_pump),
        .lid_lock   (lid_lock),
        .done       (done),
        .remaining  (remaining)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // flags = {fill_valve, motor_en, motor_spin, drain_pump, lid_lock, done}
    typedef struct {
        int         stage;
        int         remaining;
        logic [5:0] flags;
    } exp_t;
    exp_t exp_q[$];

    // Model: a cycle is a list of (stage code, duration) segments walked by enabled ticks.
    int m_mode = 0;  // 0 idle, 1 running, 2 done
    int plan_st[$];
    int plan_du[$];
    int m_idx = 0;
    int m_left = 0;

    task automatic check(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s t=%0t got %0d expected %0d", name, $time, got, want);
        end
    endtask

    function automatic void build_plan(int p);
        int wash = 8;
        int rinse = 6;
        plan_st.delete();
        plan_du.delete();
        if (p == 1) begin
            wash  = (wash / 2 < 1) ? 1 : wash / 2;
            rinse = (rinse / 2 < 1) ? 1 : rinse / 2;
        end else if (p == 2) begin
            wash = (wash * 2 > 255) ? 255 : wash * 2;
        end
        plan_st.push_back(1); plan_du.push_back(4);
        plan_st.push_back(2); plan_du.push_back(wash);
        plan_st.push_back(3); plan_du.push_back(rinse);
`ifdef AWMC_DOUBLE_RINSE_EN
        plan_st.push_back(1); plan_du.push_back(4);
        plan_st.push_back(3); plan_du.push_back(rinse);
`endif
        plan_st.push_back(4); plan_du.push_back(5);
    endfunction

    function automatic exp_t model_step(logic r, logic s, logic p, logic l, logic t,
                                        logic [1:0] sel);
        exp_t e;
        logic en;
        en = !p && l;
        if (r) begin
            m_mode = 0;
        end else if (m_mode != 1) begin
            if (s && l) begin
                build_plan(sel == 2'd3 ? 0 : int'(sel));
                m_idx  = 0;
                m_left = plan_du[0];
                m_mode = 1;
            end else if (m_mode == 2 && !s && !l) begin
                m_mode = 0;
            end
        end else if (t && en) begin
            if (m_left > 1) begin
                m_left--;
            end else begin
                m_idx++;
                if (m_idx >= plan_st.size()) m_mode = 2;
                else m_left = plan_du[m_idx];
            end
        end
        e.stage     = (m_mode == 0) ? 0 : (m_mode == 2) ? 5 : plan_st[m_idx];
        e.remaining = (m_mode == 1) ? m_left : 0;
        e.flags     = '0;
        e.flags[1]  = (m_mode == 1);
        e.flags[0]  = (m_mode == 2);
        if (m_mode == 1 && en) begin
            case (e.stage)
                1: e.flags[5] = 1'b1;
                2: e.flags[4] = 1'b1;
                3: begin e.flags[5] = 1'b1; e.flags[4] = 1'b1; end
                4: begin e.flags[3] = 1'b1; e.flags[2] = 1'b1; end
                default: ;
            endcase
        end
        return e;
    endfunction

    // Monitor: every clock edge that had stimulus produces one expected output set.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_stage", int'(stage), e.stage);
            check("sb_remaining", int'(remaining), e.remaining);
            check("sb_flags", int'({fill_valve, motor_en, motor_spin, drain_pump, lid_lock, done}),
                  int'(e.flags));
        end
    end

    task automatic cyc(logic r, logic s, logic p, logic l, logic t, logic [1:0] sel);
        @(negedge clk);
        reset = r; start = s; pause = p; lid = l; tick = t; prog_sel = sel;
        exp_q.push_back(model_step(r, s, p, l, t, sel));
        @(posedge clk);
        #2;
    endtask

    task automatic run_to_done(int want, string name, logic [1:0] sel);
        int n = 0;
        while (!done && n < 300) begin
            cyc(0, 0, 0, 1, 1, sel);
            n++;
        end
        check(name, n, want);
    endtask

    task automatic drain_to_done();
        int n = 0;
        while (!done && n < 300) begin
            cyc(0, 0, 0, 1, 1, 0);
            n++;
        end
        if (n >= 300) check("timeout_done", 0, 1);
    endtask

    // left == 0 means any remaining count within the target stage.
    task automatic run_to_model(int st, int left);
        int n = 0;
        while (!(m_mode == 1 && plan_st[m_idx] == st && (left == 0 || m_left == left))
               && n < 300) begin
            cyc(0, 0, 0, 1, 1, 0);
            n++;
        end
        if (n >= 300) check("timeout_stage", 0, 1);
    endtask

    initial begin
        int n;
        repeat (2) cyc(1, 0, 0, 1, 0, 0);
        check("rst_stage", int'(stage), 0);
        check("rst_remaining", int'(remaining), 0);
        check("rst_outs", int'({fill_valve, motor_en, motor_spin, drain_pump, lid_lock, done}), 0);

        // Normal program, start pulsed for one cycle.
        cyc(0, 1, 0, 1, 1, 0);
        check("fill_entry_stage", int'(stage), 1);
        check("fill_entry_remaining", int'(remaining), 4);
        run_to_done(NORM_T, "normal_total", 0);

        // Quick program; prog_sel changed to heavy mid-cycle must not matter.
        cyc(0, 1, 0, 1, 1, 1);
        run_to_done(QUICK_T, "quick_total", 2);

        // Heavy program doubles WASH.
        cyc(0, 1, 0, 1, 1, 2);
        run_to_done(HEAVY_T, "heavy_total", 0);

        // Pause in WASH with 5 ticks left.
        cyc(0, 1, 0, 1, 1, 0);
        run_to_model(2, 5);
        repeat (10) cyc(0, 0, 1, 1, 1, 0);
        check("pause_stage", int'(stage), 2);
        check("pause_remaining", int'(remaining), 5);
        check("pause_lock", int'(lid_lock), 1);
        check("pause_act", int'({fill_valve, motor_en, motor_spin, drain_pump}), 0);
        n = 0;
        while (stage == 3'd2 && n < 50) begin
            cyc(0, 0, 0, 1, 1, 0);
            n++;
        end
        check("pause_resume_ticks", n, 5);
        drain_to_done();

        // Lid opened in SPIN holds like pause.
        cyc(0, 1, 0, 1, 1, 0);
        run_to_model(4, 0);
        repeat (6) cyc(0, 0, 0, 0, 1, 0);
        check("lid_stage", int'(stage), 4);
        check("lid_act", int'({fill_valve, motor_en, motor_spin, drain_pump}), 0);
        check("lid_lock_held", int'(lid_lock), 1);
        drain_to_done();
        cyc(0, 0, 0, 0, 0, 0);
        check("unload_idle", int'(stage), 0);
        cyc(0, 1, 0, 0, 1, 0);
        check("start_lid_open", int'(stage), 0);

        // Reset mid-RINSE, then a full fresh cycle.
        cyc(0, 1, 0, 1, 1, 0);
        run_to_model(3, 0);
        cyc(1, 0, 0, 1, 1, 0);
        check("rinse_rst_stage", int'(stage), 0);
        check("rinse_rst_outs",
              int'({fill_valve, motor_en, motor_spin, drain_pump, lid_lock, done, remaining}), 0);
        cyc(0, 1, 0, 1, 1, 0);
        run_to_done(NORM_T, "after_reset_total", 0);

        // Randomized traffic, checked cycle by cycle by the scoreboard.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 8,
                $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 90,
                $urandom_range(0, 99) < 60, 2'($urandom));
        end
        repeat (2) @(posedge clk);
        check("sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
